// File: rtl/regfile_fwd_sb.sv
// Decode-stage register file with a priority forwarding network and a busy scoreboard.
// Each read port is fully combinational and delivers either its operand or a stall request.
module regfile_fwd_sb #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NFWD = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*DW-1:0]    rd_val,
  output logic [NRD-1:0]       rd_stall,
  input  logic                 wb_wren,
  input  logic [AW-1:0]        wb_addr,
  input  logic [DW-1:0]        wb_val,
  input  logic                 wb_sb_clr,
  input  logic [NFWD-1:0]      fwd_wren,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*DW-1:0]   fwd_val,
  input  logic [NFWD-1:0]      fwd_rdy,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_set_addr,
  input  logic                 sb_flush,
  output logic [(1<<AW)-1:0]   busy_vec
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0][DW-1:0] regs;
  logic [NREG-1:0]         busy;
  logic [NREG-1:0]         busy_next;

  // Flush and retire first, then a new issue so a fresh producer is never lost.
  always_comb begin
    busy_next = busy;
    if (sb_flush)
      busy_next = '0;
    if (wb_wren && wb_sb_clr && (wb_addr != '0))
      busy_next[wb_addr] = 1'b0;
    if (sb_set && (sb_set_addr != '0))
      busy_next[sb_set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
      busy <= '0;
    end else begin
      if (wb_wren && (wb_addr != '0))
        regs[wb_addr] <= wb_val;
      busy <= busy_next;
    end
  end

  assign busy_vec = busy;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [AW-1:0] addr;
    logic [DW-1:0] val;
    logic          stall;

    assign addr = rd_addr[p*AW +: AW];

    // Sources are layered oldest to youngest so the youngest forwarding hit has the final say.
    always_comb begin
      val   = regs[addr];
      stall = busy[addr];
      if (wb_wren && (wb_addr == addr)) begin
        val   = wb_val;
        stall = 1'b0;
      end
      for (int k = NFWD - 1; k >= 0; k--) begin
        if (fwd_wren[k] && (fwd_addr[k*AW +: AW] == addr)) begin
          val   = fwd_val[k*DW +: DW];
          stall = ~fwd_rdy[k];
        end
      end
      if (reset) begin
        val   = regs[addr];
        stall = 1'b0;
      end
      if (addr == '0) begin
        val   = '0;
        stall = 1'b0;
      end
    end

    assign rd_val[p*DW +: DW] = val;
    assign rd_stall[p]        = stall;
  end

endmodule
